// File: rtl/cnt_evt_pkg.sv
// Shared types for the counter event logger.
// Build with CNT_EVT_TSTAMP_EN defined to carry a 16-bit timestamp per record.
package cnt_evt_pkg;

    localparam int CNT_W_DEF = 10;
    localparam int TS_W      = 16;

    typedef enum logic [1:0] {
        WRAP_UP = 2'd0,
        WRAP_DN = 2'd1,
        JUMP    = 2'd2,
        DIR_CHG = 2'd3
    } evt_type_e;

    typedef enum logic {
        S_INIT,
        S_TRACK
    } state_e;

    typedef struct packed {
        evt_type_e              kind;
        logic [CNT_W_DEF-1:0]   cnt;
`ifdef CNT_EVT_TSTAMP_EN
        logic [TS_W-1:0]        tstamp;
`endif
    } evt_rec_t;

endpackage

// File: rtl/cnt_evt_fifo.sv
// Event record FIFO: DEPTH x evt_rec_t, no bypass, pointers carry a wrap bit.
// A push while full is accepted only when a pop happens on the same edge.
import cnt_evt_pkg::*;

module cnt_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  evt_rec_t      din,
    input  logic          pop,
    output evt_rec_t      dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    evt_rec_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_evt_logger.sv
// Classifies up/down counter transitions and streams event records.
// CNT_EVT_TSTAMP_EN adds evt_tstamp, a free-running cycle count per record.
import cnt_evt_pkg::*;

module cnt_evt_logger #(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              mode,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_type,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic [LW-1:0]     evt_level,
`ifdef CNT_EVT_TSTAMP_EN
    output logic [TS_W-1:0]   evt_tstamp,
`endif
    output logic              ovf,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e          state;
    state_e          state_nx;
    logic [CNT_W-1:0] cnt_q;
    logic            mode_q;

    logic            wrap_up;
    logic            wrap_dn;
    logic            step_ok;
    logic            jump;
    logic            dir_chg;
    logic            evt_hit;
    evt_type_e       evt_kind;
    evt_rec_t        rec_in;
    evt_rec_t        rec_out;
    logic            full;
    logic            empty;
    logic            pop;
    logic            drop;

`ifdef CNT_EVT_TSTAMP_EN
    logic [TS_W-1:0] tstamp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tstamp <= '0;
        else        tstamp <= tstamp + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_INIT;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt_q  <= cnt;
            mode_q <= mode;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_INIT:  state_nx = S_TRACK;
            S_TRACK: state_nx = S_TRACK;
            default: state_nx = S_INIT;
        endcase
    end

    // A wrap that coincides with a direction flip is still reported as a wrap.
    always_comb begin
        wrap_up = (cnt_q == CNT_MAX) && (cnt == '0) && (mode || mode_q);
        wrap_dn = (cnt_q == '0) && (cnt == CNT_MAX) && (!mode || !mode_q);
        step_ok = ((cnt_q != CNT_MAX) && (cnt == cnt_q + 1'b1)) ||
                  ((cnt_q != '0) && (cnt == cnt_q - 1'b1));
        jump    = (cnt != cnt_q) && !step_ok && !wrap_up && !wrap_dn;
        dir_chg = (mode != mode_q);
    end

    always_comb begin
        evt_hit  = 1'b0;
        evt_kind = WRAP_UP;
        if (state == S_TRACK) begin
            if (wrap_up) begin
                evt_hit  = 1'b1;
                evt_kind = WRAP_UP;
            end else if (wrap_dn) begin
                evt_hit  = 1'b1;
                evt_kind = WRAP_DN;
            end else if (jump) begin
                evt_hit  = 1'b1;
                evt_kind = JUMP;
            end else if (dir_chg) begin
                evt_hit  = 1'b1;
                evt_kind = DIR_CHG;
            end
        end
    end

    always_comb begin
        rec_in        = '0;
        rec_in.kind   = evt_kind;
        rec_in.cnt    = cnt;
`ifdef CNT_EVT_TSTAMP_EN
        rec_in.tstamp = tstamp;
`endif
    end

    assign pop  = evt_valid && evt_ready;
    assign drop = evt_hit && full && !pop;

    cnt_evt_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (evt_hit),
        .din   (rec_in),
        .pop   (pop),
        .dout  (rec_out),
        .full  (full),
        .empty (empty),
        .level (evt_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign evt_valid  = !empty;
    assign evt_type   = rec_out.kind;
    assign evt_cnt    = rec_out.cnt;
`ifdef CNT_EVT_TSTAMP_EN
    assign evt_tstamp = rec_out.tstamp;
`endif

endmodule

// File: tb/tb_cnt_evt_logger.sv
// Scoreboard bench for cnt_evt_logger: directed scenarios then random traffic.
// Timestamps are checked too when CNT_EVT_TSTAMP_EN is defined.
`timescale 1ns/1ps
module tb_cnt_evt_logger;

    localparam int DEPTH = 4;
    localparam int MAXV  = 1023;

    typedef struct {
        int kind;
        int c;
        int ts;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] cnt = 10'd1000;
    logic       mode = 1'b1;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [9:0] evt_cnt;
    logic [2:0] evt_level;
    logic       ovf;
    logic [7:0] drop_cnt;
`ifdef CNT_EVT_TSTAMP_EN
    logic [15:0] evt_tstamp;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   inited = 0;
    int   pc = 0;
    int   pm = 0;
    int   m_ovf = 0;
    int   m_drops = 0;
    int   cyc = 0;
    int   cur_c = 1000;
    int   cur_m = 1;

    cnt_evt_logger #(
        .CNT_W  (10),
        .DEPTH  (DEPTH),
        .DROP_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt        (cnt),
        .mode       (mode),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_type   (evt_type),
        .evt_cnt    (evt_cnt),
        .evt_level  (evt_level),
`ifdef CNT_EVT_TSTAMP_EN
        .evt_tstamp (evt_tstamp),
`endif
        .ovf        (ovf),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic on consecutive samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            inited  = 0;
            m_ovf   = 0;
            m_drops = 0;
            cyc     = 0;
        end else begin
            int c;
            int m;
            int k;
            c = int'(cnt);
            m = int'(mode);
            k = -1;
            if (inited) begin
                if (pc == MAXV && c == 0 && (m == 1 || pm == 1))
                    k = 0;
                else if (pc == 0 && c == MAXV && (m == 0 || pm == 0))
                    k = 1;
                else if (c != pc && c != pc + 1 && c != pc - 1)
                    k = 2;
                else if (m != pm)
                    k = 3;
                if (k >= 0) begin
                    if (sb.size() < DEPTH) begin
                        sb.push_back('{kind: k, c: c, ts: cyc});
                    end else begin
                        m_ovf = 1;
                        if (m_drops < 255) m_drops++;
                    end
                end
            end
            inited = 1;
            pc  = c;
            pm  = m;
            cyc = (cyc + 1) % 65536;
        end
    end

    // Monitor: compare DUT stream against the scoreboard between edges.
    always @(negedge clk) begin
        bit ev;
        ev = (sb.size() > 0);
        n_vec++;
        if (evt_valid !== ev) begin
            n_err++;
            $display("FAIL valid t=%0t got %0b exp %0b", $time, evt_valid, ev);
        end
        n_vec++;
        if (int'(evt_level) != sb.size()) begin
            n_err++;
            $display("FAIL level t=%0t got %0d exp %0d", $time, evt_level, sb.size());
        end
        n_vec++;
        if (int'(ovf) != m_ovf || int'(drop_cnt) != m_drops) begin
            n_err++;
            $display("FAIL drops t=%0t got ovf=%0b n=%0d exp ovf=%0d n=%0d",
                     $time, ovf, drop_cnt, m_ovf, m_drops);
        end
        if (!rst_n) begin
            n_vec++;
            if (evt_type !== 2'd0 || evt_cnt !== 10'd0) begin
                n_err++;
                $display("FAIL rst_rec got type=%0d cnt=%0d exp 0 0", evt_type, evt_cnt);
            end
        end
        if (ev && evt_ready) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (int'(evt_type) != e.kind || int'(evt_cnt) != e.c) begin
                n_err++;
                $display("FAIL record t=%0t got type=%0d cnt=%0d exp type=%0d cnt=%0d",
                         $time, evt_type, evt_cnt, e.kind, e.c);
            end
`ifdef CNT_EVT_TSTAMP_EN
            n_vec++;
            if (int'(evt_tstamp) != e.ts) begin
                n_err++;
                $display("FAIL tstamp got %0d exp %0d", evt_tstamp, e.ts);
            end
`endif
        end
    end

    task automatic drive(input int c, input int m);
        cnt   = 10'(c);
        mode  = m[0];
        cur_c = c;
        cur_m = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // wrap up from 1000
        for (int v = 1000; v <= MAXV; v++) drive(v, 1);
        drive(0, 1);
        // wrap down, then wrong-direction wrap is a jump
        drive(2, 0);
        drive(1, 0);
        drive(0, 0);
        drive(MAXV, 0);
        drive(MAXV, 1);
        drive(0, 1);
        drive(MAXV, 1);
        // upstream reset jump
        drive(500, 1);
        drive(7, 1);
        // direction change at steady count
        drive(300, 1);
        drive(300, 1);
        drive(300, 0);
        // wrap with simultaneous direction flip
        drive(MAXV, 1);
        drive(0, 0);
        drive(0, 0);
        // overflow: six events into four slots
        evt_ready = 1'b0;
        for (int i = 1; i <= 6; i++) drive(i * 100, 0);
        drive(600, 0);
        evt_ready = 1'b1;
        drive(700, 0);
        for (int i = 0; i < 6; i++) drive(700, 0);
        // mid-operation reset with three queued records
        evt_ready = 1'b0;
        drive(10, 0);
        drive(20, 0);
        drive(30, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        evt_ready = 1'b1;
        drive(40, 0);
        drive(41, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            int c;
            int m;
            r = int'($urandom_range(0, 99));
            m = ($urandom_range(0, 99) < 8) ? 1 - cur_m : cur_m;
            if (r < 70)
                c = (m == 1) ? (cur_c + 1) % 1024 : (cur_c + 1023) % 1024;
            else if (r < 80)
                c = cur_c;
            else if (r < 90)
                c = int'($urandom_range(0, MAXV));
            else
                c = ($urandom_range(0, 1) == 1) ? MAXV : 0;
            evt_ready = ($urandom_range(0, 2) != 0);
            drive(c, m);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) drive(cur_c, cur_m);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
